// File: rtl/button_step_conditioner.sv
// Turns the two raw push-buttons into clean, mutually exclusive up/down step pulses,
// with auto-repeat while a button is held and a lockout while both buttons are pressed.
module button_step_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 65535,
    parameter int unsigned REPEAT_DELAY    = 25000000,
    parameter int unsigned REPEAT_PERIOD   = 5000000,
    parameter int unsigned CNT_W           = 26
) (
    input  logic sysclock,
    input  logic reset,
    input  logic raw_up,
    input  logic raw_down,
    output logic up_pulse,
    output logic down_pulse,
    output logic up_held,
    output logic down_held,
    output logic lockout
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        REPEAT
    } state_t;

    localparam logic [CNT_W-1:0] DEB_LIMIT  = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] DELAY_LOAD = CNT_W'(REPEAT_DELAY);
    localparam logic [CNT_W-1:0] PERIOD_LOAD = CNT_W'(REPEAT_PERIOD);
    localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);

    // Index 0 is the up button, index 1 the down button.
    logic [1:0]       raw;
    logic [1:0]       sync1_q, sync1_d;
    logic [1:0]       sync2_q, sync2_d;
    logic [1:0]       deb_q, deb_d;
    logic [CNT_W-1:0] deb_cnt_q [2];
    logic [CNT_W-1:0] deb_cnt_d [2];
    state_t           state_q [2];
    state_t           state_d [2];
    logic [CNT_W-1:0] timer_q [2];
    logic [CNT_W-1:0] timer_d [2];
    logic [1:0]       pulse_q, pulse_d;
    logic             lockout_q, lockout_d;

    assign raw = {raw_down, raw_up};

    // The debounced level only moves once the synced input has disagreed with it long enough.
    always_comb begin
        sync1_d = raw;
        sync2_d = sync1_q;
        deb_d   = deb_q;
        for (int i = 0; i < 2; i++) begin
            deb_cnt_d[i] = '0;
            if (sync2_q[i] != deb_q[i]) begin
                if (deb_cnt_q[i] == DEB_LIMIT) begin
                    deb_d[i] = sync2_q[i];
                end else begin
                    deb_cnt_d[i] = deb_cnt_q[i] + ONE;
                end
            end
        end
    end

    // Lockout latches on both-pressed and only releases once both buttons are fully up.
    always_comb begin
        lockout_d = lockout_q;
        if (deb_d == 2'b11) begin
            lockout_d = 1'b1;
        end else if (deb_d == 2'b00) begin
            lockout_d = 1'b0;
        end
    end

    // Edges are taken from the next debounced level so a release beats a same-cycle repeat.
    always_comb begin
        pulse_d = '0;
        for (int i = 0; i < 2; i++) begin
            state_d[i] = state_q[i];
            timer_d[i] = timer_q[i];
            if (lockout_d) begin
                state_d[i] = IDLE;
                timer_d[i] = '0;
            end else begin
                case (state_q[i])
                    IDLE: begin
                        if (deb_d[i] && !deb_q[i]) begin
                            pulse_d[i] = 1'b1;
                            timer_d[i] = DELAY_LOAD;
                            state_d[i] = WAIT;
                        end
                    end
                    WAIT, REPEAT: begin
                        if (!deb_d[i]) begin
                            state_d[i] = IDLE;
                            timer_d[i] = '0;
                        end else if (timer_q[i] == ONE) begin
                            pulse_d[i] = 1'b1;
                            timer_d[i] = PERIOD_LOAD;
                            state_d[i] = REPEAT;
                        end else if (timer_q[i] != '0) begin
                            timer_d[i] = timer_q[i] - ONE;
                        end
                    end
                    default: begin
                        state_d[i] = IDLE;
                        timer_d[i] = '0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge sysclock) begin
        if (reset) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            deb_q     <= '0;
            pulse_q   <= '0;
            lockout_q <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                deb_cnt_q[i] <= '0;
                timer_q[i]   <= '0;
                state_q[i]   <= IDLE;
            end
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            deb_q     <= deb_d;
            pulse_q   <= pulse_d;
            lockout_q <= lockout_d;
            for (int i = 0; i < 2; i++) begin
                deb_cnt_q[i] <= deb_cnt_d[i];
                timer_q[i]   <= timer_d[i];
                state_q[i]   <= state_d[i];
            end
        end
    end

    assign up_pulse   = pulse_q[0];
    assign down_pulse = pulse_q[1];
    assign up_held    = deb_q[0];
    assign down_held  = deb_q[1];
    assign lockout    = lockout_q;

endmodule
